// File: rtl/ks_add_arbiter.sv
// Round-robin arbiter sharing one registered Kogge-Stone adder among NREQ requesters.
// One operation in flight: IDLE (accept) -> WAIT (adder result) -> RESP (hold until taken).
// A per-requester carry register lets a requester chain multi-word additions.

// Registered Kogge-Stone adder: the sum of the current inputs appears one cycle later.
module kogge_stone_Nbit #(
    parameter int unsigned bw = 32
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic [bw-1:0] i_a,
    input  logic [bw-1:0] i_b,
    input  logic          i_cin,
    output logic [bw-1:0] o_sum,
    output logic          o_cout
);

    localparam int unsigned Levels = $clog2(bw);

    logic [bw:0] w_res;
    logic [bw-1:0] r_sum;
    logic          r_cout;

    // Parallel-prefix carry network; carry-in is folded into bit 0's generate.
    function automatic logic [bw:0] ks_add(input logic [bw-1:0] a, input logic [bw-1:0] b,
                                           input logic cin);
        logic [bw-1:0] p0;
        logic [bw-1:0] g;
        logic [bw-1:0] p;
        logic [bw-1:0] g_n;
        logic [bw-1:0] p_n;
        logic [bw:0]   res;
        p0   = a ^ b;
        g    = a & b;
        g[0] = g[0] | (p0[0] & cin);
        p    = p0;
        for (int l = 0; l < int'(Levels); l++) begin
            g_n = g;
            p_n = p;
            for (int i = 0; i < int'(bw); i++) begin
                if (i >= (1 << l)) begin
                    g_n[i] = g[i] | (p[i] & g[i - (1 << l)]);
                    p_n[i] = p[i] & p[i - (1 << l)];
                end
            end
            g = g_n;
            p = p_n;
        end
        res    = '0;
        res[0] = p0[0] ^ cin;
        for (int i = 1; i < int'(bw); i++) begin
            res[i] = p0[i] ^ g[i - 1];
        end
        res[bw] = g[bw - 1];
        return res;
    endfunction

    // Combinational prefix sum of the current inputs.
    always_comb begin
        w_res = ks_add(i_a, i_b, i_cin);
    end

    // Output register: holds the result of the previous cycle's operands.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_sum  <= '0;
            r_cout <= 1'b0;
        end else begin
            r_sum  <= w_res[bw-1:0];
            r_cout <= w_res[bw];
        end
    end

    assign o_sum  = r_sum;
    assign o_cout = r_cout;

endmodule

module ks_add_arbiter #(
    parameter int unsigned BW   = 32,
    parameter int unsigned NREQ = 4,
    parameter int unsigned IDW  = $clog2(NREQ)
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic [NREQ-1:0]    i_req_valid,
    output logic [NREQ-1:0]    o_req_ready,
    input  logic [NREQ*BW-1:0] i_req_a,
    input  logic [NREQ*BW-1:0] i_req_b,
    input  logic [NREQ-1:0]    i_req_cin,
    input  logic [NREQ-1:0]    i_req_chain,
    output logic               o_rsp_valid,
    input  logic               i_rsp_ready,
    output logic [IDW-1:0]     o_rsp_id,
    output logic [BW-1:0]      o_rsp_sum,
    output logic               o_rsp_cout
);

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StResp
    } state_e;

    state_e          r_state;
    state_e          w_state_d;
    logic [IDW-1:0]  r_last;
    logic [IDW-1:0]  r_cur_id;
    logic [NREQ-1:0] r_carry;
    logic [BW-1:0]   r_rsp_sum;
    logic            r_rsp_cout;
    logic [IDW-1:0]  r_rsp_id;

    logic            w_any;
    logic [IDW-1:0]  w_gnt_id;
    logic            w_accept;
    logic [BW-1:0]   w_add_a;
    logic [BW-1:0]   w_add_b;
    logic            w_add_cin;
    logic [BW-1:0]   w_add_sum;
    logic            w_add_cout;

    // Round-robin search from last+1; iterating downwards leaves the nearest valid as winner.
    always_comb begin
        w_any    = 1'b0;
        w_gnt_id = '0;
        for (int k = int'(NREQ); k >= 1; k--) begin
            if (i_req_valid[(int'(r_last) + k) % int'(NREQ)]) begin
                w_any    = 1'b1;
                w_gnt_id = IDW'((int'(r_last) + k) % int'(NREQ));
            end
        end
    end

    // Handshake only in IDLE; resetn gates ready so nothing is accepted while held in reset.
    assign w_accept = resetn && (r_state == StIdle) && w_any;

    // One-hot ready for the granted requester.
    always_comb begin
        o_req_ready = '0;
        if (w_accept) begin
            o_req_ready[w_gnt_id] = 1'b1;
        end
    end

    // Adder operand mux: driven from the winner only in the accept cycle, else zero.
    always_comb begin
        w_add_a   = '0;
        w_add_b   = '0;
        w_add_cin = 1'b0;
        if (w_accept) begin
            w_add_a   = i_req_a[int'(w_gnt_id) * int'(BW) +: BW];
            w_add_b   = i_req_b[int'(w_gnt_id) * int'(BW) +: BW];
            w_add_cin = i_req_chain[w_gnt_id] ? r_carry[w_gnt_id] : i_req_cin[w_gnt_id];
        end
    end

    kogge_stone_Nbit #(
        .bw(BW)
    ) u_adder (
        .clk    (clk),
        .resetn (resetn),
        .i_a    (w_add_a),
        .i_b    (w_add_b),
        .i_cin  (w_add_cin),
        .o_sum  (w_add_sum),
        .o_cout (w_add_cout)
    );

    // Next-state logic for the single-operation pipeline.
    always_comb begin
        w_state_d = r_state;
        unique case (r_state)
            StIdle: if (w_any) w_state_d = StWait;
            StWait: w_state_d = StResp;
            StResp: if (i_rsp_ready) w_state_d = StIdle;
            default: w_state_d = StIdle;
        endcase
    end

    // State, grant pointer and in-flight requester id.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state  <= StIdle;
            r_last   <= IDW'(NREQ - 1);
            r_cur_id <= '0;
        end else begin
            r_state <= w_state_d;
            if (w_accept) begin
                r_last   <= w_gnt_id;
                r_cur_id <= w_gnt_id;
            end
        end
    end

    // Capture the adder result and the requester's carry at the end of WAIT.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_rsp_sum  <= '0;
            r_rsp_cout <= 1'b0;
            r_rsp_id   <= '0;
            r_carry    <= '0;
        end else if (r_state == StWait) begin
            r_rsp_sum         <= w_add_sum;
            r_rsp_cout        <= w_add_cout;
            r_rsp_id          <= r_cur_id;
            r_carry[r_cur_id] <= w_add_cout;
        end
    end

    assign o_rsp_valid = (r_state == StResp);
    assign o_rsp_sum   = r_rsp_sum;
    assign o_rsp_cout  = r_rsp_cout;
    assign o_rsp_id    = r_rsp_id;

endmodule

// File: tb/tb_ks_add_arbiter.sv
// Self-checking bench for ks_add_arbiter: directed scenarios plus a randomized
// regression against a transaction-level model (A+B+cin arithmetic, per-requester carry).
module tb_ks_add_arbiter;

    localparam int BW   = 32;
    localparam int NREQ = 4;
    localparam int IDW  = 2;

    logic                 clk = 1'b0;
    logic                 resetn;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ-1:0]      req_ready;
    logic [NREQ*BW-1:0]   req_a;
    logic [NREQ*BW-1:0]   req_b;
    logic [NREQ-1:0]      req_cin;
    logic [NREQ-1:0]      req_chain;
    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [IDW-1:0]       rsp_id;
    logic [BW-1:0]        rsp_sum;
    logic                 rsp_cout;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    bit m_carry [NREQ];
    int m_last;

    ks_add_arbiter #(
        .BW   (BW),
        .NREQ (NREQ),
        .IDW  (IDW)
    ) dut (
        .clk         (clk),
        .resetn      (resetn),
        .i_req_valid (req_valid),
        .o_req_ready (req_ready),
        .i_req_a     (req_a),
        .i_req_b     (req_b),
        .i_req_cin   (req_cin),
        .i_req_chain (req_chain),
        .o_rsp_valid (rsp_valid),
        .i_rsp_ready (rsp_ready),
        .o_rsp_id    (rsp_id),
        .o_rsp_sum   (rsp_sum),
        .o_rsp_cout  (rsp_cout)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // First asserted valid in the order last+1, last+2, ... (mod NREQ); -1 if none.
    function automatic int exp_grant(logic [NREQ-1:0] v, int last);
        for (int k = 1; k <= NREQ; k++) begin
            if (v[(last + k) % NREQ]) return (last + k) % NREQ;
        end
        return -1;
    endfunction

    function automatic logic [NREQ-1:0] onehot(int id);
        logic [NREQ-1:0] r;
        r = '0;
        if (id >= 0) r[id] = 1'b1;
        return r;
    endfunction

    function automatic logic [BW:0] ref_add(logic [BW-1:0] a, logic [BW-1:0] b, logic cin);
        return {1'b0, a} + {1'b0, b} + {{BW{1'b0}}, cin};
    endfunction

    task automatic set_slot(int id, logic [BW-1:0] a, logic [BW-1:0] b, logic cin, logic chain);
        req_a[id*BW +: BW] = a;
        req_b[id*BW +: BW] = b;
        req_cin[id]        = cin;
        req_chain[id]      = chain;
    endtask

    task automatic clear_inputs();
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        req_cin   = '0;
        req_chain = '0;
        rsp_ready = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        resetn = 1'b0;
        clear_inputs();
        for (int i = 0; i < NREQ; i++) m_carry[i] = 1'b0;
        m_last = NREQ - 1;
        @(negedge clk);
        @(negedge clk);
        resetn = 1'b1;
    endtask

    // One directed operation from requester id with rsp_ready held high.
    task automatic run_op(int id, logic [BW-1:0] a, logic [BW-1:0] b, logic cin, logic chain);
        logic [BW:0] exp;
        bit got;
        @(negedge clk);
        set_slot(id, a, b, cin, chain);
        req_valid = onehot(id);
        rsp_ready = 1'b1;
        #1;
        got = 0;
        for (int n = 0; n < 20; n++) begin
            if (req_ready !== '0) begin
                got = 1;
                break;
            end
            @(negedge clk);
            #1;
        end
        checks++;
        if (!got || req_ready !== onehot(id)) begin
            failures++;
            $display("FAIL op_grant id=%0d: req_ready=%b required=%b", id, req_ready, onehot(id));
            req_valid = '0;
            return;
        end
        exp    = ref_add(a, b, chain ? m_carry[id] : cin);
        m_last = id;
        @(negedge clk);
        req_valid = '0;
        #1;
        checks++;
        if (rsp_valid !== 1'b0 || req_ready !== '0) begin
            failures++;
            $display("FAIL op_wait id=%0d: rsp_valid=%b req_ready=%b required 0/0", id, rsp_valid,
                     req_ready);
        end
        @(negedge clk);
        #1;
        checks++;
        if (rsp_valid !== 1'b1 || rsp_sum !== exp[BW-1:0] || rsp_cout !== exp[BW] ||
            rsp_id !== IDW'(id)) begin
            failures++;
            $display("FAIL op_resp id=%0d: valid=%b sum=%h cout=%b rid=%0d required 1 %h %b %0d", id,
                     rsp_valid, rsp_sum, rsp_cout, rsp_id, exp[BW-1:0], exp[BW], id);
        end
        m_carry[id] = exp[BW];
        @(negedge clk);
        #1;
        checks++;
        if (rsp_valid !== 1'b0) begin
            failures++;
            $display("FAIL op_done id=%0d: rsp_valid=%b required 0", id, rsp_valid);
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        resetn = 1'b0;
        clear_inputs();
        req_valid = '1;
        #1;
        checks++;
        if (req_ready !== '0 || rsp_valid !== 1'b0 || rsp_sum !== '0 || rsp_cout !== 1'b0 ||
            rsp_id !== '0) begin
            failures++;
            $display("FAIL reset_outputs: ready=%b valid=%b sum=%h cout=%b id=%0d required all 0",
                     req_ready, rsp_valid, rsp_sum, rsp_cout, rsp_id);
        end
        do_reset();
    endtask

    task automatic test_single_op();
        do_reset();
        run_op(0, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
    endtask

    task automatic test_chain();
        do_reset();
        run_op(2, 32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0);
        run_op(1, 32'h5, 32'h7, 1'b0, 1'b0);
        run_op(1, 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0);
        run_op(1, 32'h0, 32'h0, 1'b0, 1'b1);
        run_op(1, 32'h1234_5678, 32'h0, 1'b1, 1'b0);
        run_op(2, 32'h0, 32'h0, 1'b0, 1'b1);
    endtask

    task automatic test_round_robin();
        int order [5] = '{0, 1, 2, 3, 0};
        int last_acc;
        int g;
        logic [BW:0] exp;
        do_reset();
        for (int i = 0; i < NREQ; i++) set_slot(i, $urandom, $urandom, 1'($urandom), 1'b0);
        req_valid = '1;
        rsp_ready = 1'b1;
        last_acc  = -1;
        for (int op = 0; op < 5; op++) begin
            #1;
            for (int n = 0; n < 20; n++) begin
                if (req_ready !== '0) break;
                @(negedge clk);
                #1;
            end
            g = exp_grant(req_valid, m_last);
            checks++;
            if (req_ready !== onehot(order[op]) || g != order[op]) begin
                failures++;
                $display("FAIL rr_grant op=%0d: req_ready=%b required=%b", op, req_ready,
                         onehot(order[op]));
            end
            if (last_acc >= 0) begin
                checks++;
                if (cyc - last_acc != 3) begin
                    failures++;
                    $display("FAIL rr_throughput op=%0d: interval=%0d required 3", op,
                             cyc - last_acc);
                end
            end
            last_acc = cyc;
            exp = ref_add(req_a[order[op]*BW +: BW], req_b[order[op]*BW +: BW],
                          req_cin[order[op]]);
            m_last = order[op];
            @(negedge clk);
            set_slot(order[op], $urandom, $urandom, 1'($urandom), 1'b0);
            @(negedge clk);
            #1;
            checks++;
            if (rsp_valid !== 1'b1 || rsp_id !== IDW'(order[op]) || rsp_sum !== exp[BW-1:0] ||
                rsp_cout !== exp[BW]) begin
                failures++;
                $display("FAIL rr_resp op=%0d: valid=%b id=%0d sum=%h cout=%b required 1 %0d %h %b",
                         op, rsp_valid, rsp_id, rsp_sum, rsp_cout, order[op], exp[BW-1:0],
                         exp[BW]);
            end
            @(negedge clk);
        end
        req_valid = '0;
    endtask

    task automatic test_back_pressure();
        logic [BW:0] exp;
        logic [BW-1:0] a;
        logic [BW-1:0] b;
        do_reset();
        a = $urandom;
        b = $urandom;
        set_slot(3, a, b, 1'b1, 1'b0);
        set_slot(1, $urandom, $urandom, 1'b0, 1'b0);
        req_valid = onehot(3);
        rsp_ready = 1'b0;
        exp = ref_add(a, b, 1'b1);
        #1;
        checks++;
        if (req_ready !== onehot(3)) begin
            failures++;
            $display("FAIL bp_grant: req_ready=%b required=%b", req_ready, onehot(3));
        end
        @(negedge clk);
        req_valid = onehot(1);
        @(negedge clk);
        #1;
        checks++;
        if (rsp_valid !== 1'b1 || rsp_sum !== exp[BW-1:0] || rsp_cout !== exp[BW]) begin
            failures++;
            $display("FAIL bp_resp: valid=%b sum=%h cout=%b required 1 %h %b", rsp_valid, rsp_sum,
                     rsp_cout, exp[BW-1:0], exp[BW]);
        end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            #1;
            checks++;
            if (rsp_valid !== 1'b1 || rsp_sum !== exp[BW-1:0] || req_ready !== '0) begin
                failures++;
                $display("FAIL bp_hold cycle=%0d: valid=%b sum=%h req_ready=%b required 1 %h 0", i,
                         rsp_valid, rsp_sum, req_ready, exp[BW-1:0]);
            end
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        #1;
        checks++;
        if (req_ready !== onehot(1) || rsp_valid !== 1'b0) begin
            failures++;
            $display("FAIL bp_next_accept: req_ready=%b valid=%b required %b 0", req_ready,
                     rsp_valid, onehot(1));
        end
    endtask

    task automatic test_reset_mid_op();
        do_reset();
        run_op(2, 32'hFFFF_FFFF, 32'h3, 1'b0, 1'b0);
        @(negedge clk);
        set_slot(0, $urandom, $urandom, 1'b0, 1'b0);
        req_valid = onehot(0);
        rsp_ready = 1'b1;
        #1;
        checks++;
        if (req_ready !== onehot(0)) begin
            failures++;
            $display("FAIL rst_mid_grant: req_ready=%b required=%b", req_ready, onehot(0));
        end
        @(negedge clk);
        req_valid = '0;
        resetn    = 1'b0;
        #1;
        checks++;
        if (req_ready !== '0 || rsp_valid !== 1'b0 || rsp_sum !== '0 || rsp_cout !== 1'b0 ||
            rsp_id !== '0) begin
            failures++;
            $display("FAIL rst_mid_outputs: ready=%b valid=%b sum=%h cout=%b id=%0d required 0",
                     req_ready, rsp_valid, rsp_sum, rsp_cout, rsp_id);
        end
        for (int i = 0; i < NREQ; i++) m_carry[i] = 1'b0;
        m_last = NREQ - 1;
        @(negedge clk);
        resetn = 1'b1;
        run_op(2, 32'h0, 32'h0, 1'b1, 1'b1);
    endtask

    task automatic test_random(int nops);
        bit            pend [NREQ];
        logic [BW-1:0] pa   [NREQ];
        logic [BW-1:0] pb   [NREQ];
        bit            pc   [NREQ];
        bit            pch  [NREQ];
        bit            busy;
        int            age;
        int            done;
        int            g;
        int            exp_id;
        int            ncyc;
        logic [BW:0]   exp_res;
        do_reset();
        for (int i = 0; i < NREQ; i++) pend[i] = 0;
        busy    = 0;
        age     = 0;
        done    = 0;
        ncyc    = 0;
        exp_id  = 0;
        exp_res = '0;
        while (done < nops && ncyc < 80000) begin
            @(negedge clk);
            ncyc++;
            for (int i = 0; i < NREQ; i++) begin
                if (!pend[i] && $urandom_range(2) == 0) begin
                    pend[i] = 1;
                    pa[i]   = $urandom;
                    pb[i]   = ($urandom_range(3) == 0) ? ~pa[i] : $urandom;
                    pc[i]   = 1'($urandom);
                    pch[i]  = 1'($urandom);
                end
                req_valid[i] = pend[i];
                if (pend[i]) set_slot(i, pa[i], pb[i], pc[i], pch[i]);
            end
            rsp_ready = ($urandom_range(3) != 0);
            #1;
            if (!busy) begin
                g = exp_grant(req_valid, m_last);
                checks++;
                if (req_ready !== onehot(g) || rsp_valid !== 1'b0) begin
                    failures++;
                    $display("FAIL rnd_idle cyc=%0d: req_ready=%b valid=%b required %b 0", ncyc,
                             req_ready, rsp_valid, onehot(g));
                end
                if (g >= 0) begin
                    exp_res = ref_add(pa[g], pb[g], pch[g] ? m_carry[g] : pc[g]);
                    exp_id  = g;
                    m_last  = g;
                    pend[g] = 0;
                    busy    = 1;
                    age     = 0;
                end
            end else begin
                age++;
                checks++;
                if (req_ready !== '0) begin
                    failures++;
                    $display("FAIL rnd_busy_ready cyc=%0d: req_ready=%b required 0", ncyc,
                             req_ready);
                end
                if (age == 1) begin
                    checks++;
                    if (rsp_valid !== 1'b0) begin
                        failures++;
                        $display("FAIL rnd_wait cyc=%0d: rsp_valid=%b required 0", ncyc,
                                 rsp_valid);
                    end
                end else begin
                    checks++;
                    if (rsp_valid !== 1'b1 || rsp_sum !== exp_res[BW-1:0] ||
                        rsp_cout !== exp_res[BW] || rsp_id !== IDW'(exp_id)) begin
                        failures++;
                        $display("FAIL rnd_resp op=%0d: valid=%b sum=%h cout=%b id=%0d required 1 %h %b %0d",
                                 done, rsp_valid, rsp_sum, rsp_cout, rsp_id, exp_res[BW-1:0],
                                 exp_res[BW], exp_id);
                    end
                    if (age == 2) m_carry[exp_id] = exp_res[BW];
                    if (rsp_ready) begin
                        busy = 0;
                        done++;
                    end
                end
            end
        end
        checks++;
        if (done < nops) begin
            failures++;
            $display("FAIL rnd_budget: ops=%0d required %0d within cycle budget", done, nops);
        end
        clear_inputs();
    endtask

    initial begin
        resetn = 1'b0;
        clear_inputs();
        m_last = NREQ - 1;
        for (int i = 0; i < NREQ; i++) m_carry[i] = 1'b0;
        test_reset();
        test_single_op();
        test_chain();
        test_round_robin();
        test_back_pressure();
        test_reset_mid_op();
        test_random(10000);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
